// File: rtl/ahb_sramc_pkg.sv
// Shared AHB encodings, controller FSM states and byte-enable helpers for the banked SRAM controller.
package ahb_sramc_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HSIZE_DWORD   = 3'b011;

   typedef enum logic [1:0] {ACTIVE, STALL, ERR1, ERR2} sramc_state_e;

   function automatic logic size_ok(input logic [2:0] size, input int nbytes);
      return (32'd1 << size) <= 32'(nbytes);
   endfunction

   // Lane mask for up to 8 byte lanes; the offset is first reduced to the bus width.
   function automatic logic [7:0] be_calc(input logic [2:0] size, input logic [2:0] off, input int nbytes);
      logic [2:0] o;
      logic [7:0] be;
      o = off & 3'(nbytes - 1);
      case (size)
         HSIZE_BYTE:  be = 8'h01 << o;
         HSIZE_HALF:  be = 8'h03 << {o[2:1], 1'b0};
         HSIZE_WORD:  be = 8'h0F << {o[2], 2'b00};
         HSIZE_DWORD: be = 8'hFF;
         default:     be = 8'h00;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_sramc_decode.sv
// Combinational split of an AHB address/size into bank word, bank index, byte lanes and error flags.
module ahb_sramc_decode
   import ahb_sramc_pkg::*;
#(
   parameter int AHB_ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int BANK_ADDR_WIDTH = 12,
   parameter int NUM_BANKS       = 4
) (
   input  logic [AHB_ADDR_WIDTH-1:0]      haddr_i,
   input  logic [2:0]                     hsize_i,
   output logic [BANK_ADDR_WIDTH-1:0]     word_o,
   output logic [$clog2(NUM_BANKS)-1:0]   bank_o,
   output logic [DATA_WIDTH/8-1:0]        be_o,
   output logic                           size_err_o,
   output logic                           range_err_o
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int BB     = $clog2(NBYTES);
   localparam int BKW    = $clog2(NUM_BANKS);
   localparam int TOP    = BB + BANK_ADDR_WIDTH + BKW;

   logic [2:0] off;
   logic [7:0] be_full;
   logic       unused_be;

   assign off         = 3'(haddr_i[BB-1:0]);
   assign word_o      = haddr_i[BB +: BANK_ADDR_WIDTH];
   assign bank_o      = haddr_i[BB + BANK_ADDR_WIDTH +: BKW];
   assign range_err_o = (haddr_i >> TOP) != '0;
   assign size_err_o  = !size_ok(hsize_i, NBYTES);
   assign be_full     = be_calc(hsize_i, off, NBYTES);
   assign be_o        = be_full[NBYTES-1:0];
   assign unused_be   = ^be_full;

endmodule

// File: rtl/ahb_sramc_mb.sv
// AHB-Lite slave for NUM_BANKS single-port SRAMs; zero-wait reads/writes, one wait state on a write->read port conflict.
// hready_resp drops only for that stall and the first ERROR cycle; SRAMC_ADDR_CHECK_EN adds ERROR for out-of-range addresses.
module ahb_sramc_mb
   import ahb_sramc_pkg::*;
#(
   parameter int AHB_ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int BANK_ADDR_WIDTH = 12,
   parameter int NUM_BANKS       = 4
) (
   input  logic                            hclk,
   input  logic                            hreset,
   input  logic                            hsel,
   input  logic                            hready,
   input  logic [AHB_ADDR_WIDTH-1:0]       haddr,
   input  logic                            hwrite,
   input  logic [2:0]                      hsize,
   input  logic [1:0]                      htrans,
   input  logic [DATA_WIDTH-1:0]           hwdata,
   output logic [DATA_WIDTH-1:0]           hrdata,
   output logic                            hready_resp,
   output logic [1:0]                      hresp,
   output logic [NUM_BANKS-1:0]            sram_cs_n,
   output logic                            sram_we_n,
   output logic [DATA_WIDTH/8-1:0]         sram_be_n,
   output logic [BANK_ADDR_WIDTH-1:0]      sram_addr,
   output logic [DATA_WIDTH-1:0]           sram_wdata,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] sram_rdata
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int BKW    = $clog2(NUM_BANKS);

   typedef struct packed {
      logic [BANK_ADDR_WIDTH-1:0] word;
      logic [BKW-1:0]             bank;
      logic [NBYTES-1:0]          be;
   } wphase_t;

   logic [BANK_ADDR_WIDTH-1:0] dec_word;
   logic [BKW-1:0]             dec_bank;
   logic [NBYTES-1:0]          dec_be;
   logic                       size_err, range_err, addr_err;
   logic                       unused_ok;

   ahb_sramc_decode #(
      .AHB_ADDR_WIDTH (AHB_ADDR_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .BANK_ADDR_WIDTH(BANK_ADDR_WIDTH),
      .NUM_BANKS      (NUM_BANKS)
   ) u_decode (
      .haddr_i    (haddr),
      .hsize_i    (hsize),
      .word_o     (dec_word),
      .bank_o     (dec_bank),
      .be_o       (dec_be),
      .size_err_o (size_err),
      .range_err_o(range_err)
   );

`ifdef SRAMC_ADDR_CHECK_EN
   assign addr_err = range_err;
`else
   logic unused_range;
   assign addr_err     = 1'b0;
   assign unused_range = range_err;
`endif
   assign unused_ok = htrans[0];

   sramc_state_e               state_q;
   logic                       hready_resp_q;
   logic [1:0]                 hresp_q;
   logic                       wr_pend_q, wr_pend_d;
   wphase_t                    wr_q, wr_d;
   logic                       rd_pend_q, rd_pend_d;
   logic [BKW-1:0]             rd_bank_q, rd_bank_d;
   logic [BANK_ADDR_WIDTH-1:0] st_word_q, st_word_d;
   logic [BKW-1:0]             st_bank_q, st_bank_d;

   logic acc_ok, bad, good_rd, good_wr, conflict, issue_rd;

   assign acc_ok   = hsel && hready && htrans[1] && (state_q == ACTIVE || state_q == ERR2);
   assign bad      = acc_ok && (size_err || addr_err);
   assign good_rd  = acc_ok && !bad && !hwrite;
   assign good_wr  = acc_ok && !bad && hwrite;
   assign conflict = good_rd && wr_pend_q;
   assign issue_rd = good_rd && !wr_pend_q;

   always_comb begin
      wr_pend_d = good_wr;
      wr_d      = good_wr ? '{word: dec_word, bank: dec_bank, be: dec_be} : wr_q;
      rd_pend_d = issue_rd || (state_q == STALL);
      rd_bank_d = (state_q == STALL) ? st_bank_q : (issue_rd ? dec_bank : rd_bank_q);
      st_word_d = conflict ? dec_word : st_word_q;
      st_bank_d = conflict ? dec_bank : st_bank_q;
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         wr_pend_q <= 1'b0;
         wr_q      <= '0;
         rd_pend_q <= 1'b0;
         rd_bank_q <= '0;
         st_word_q <= '0;
         st_bank_q <= '0;
      end else begin
         wr_pend_q <= wr_pend_d;
         wr_q      <= wr_d;
         rd_pend_q <= rd_pend_d;
         rd_bank_q <= rd_bank_d;
         st_word_q <= st_word_d;
         st_bank_q <= st_bank_d;
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q       <= ACTIVE;
         hready_resp_q <= 1'b1;
         hresp_q       <= HRESP_OKAY;
      end else begin
         case (state_q)
            ACTIVE, ERR2: begin
               if (bad) begin
                  state_q       <= ERR1;
                  hready_resp_q <= 1'b0;
                  hresp_q       <= HRESP_ERROR;
               end else if (conflict) begin
                  state_q       <= STALL;
                  hready_resp_q <= 1'b0;
                  hresp_q       <= HRESP_OKAY;
               end else begin
                  state_q       <= ACTIVE;
                  hready_resp_q <= 1'b1;
                  hresp_q       <= HRESP_OKAY;
               end
            end
            ERR1: begin
               state_q       <= ERR2;
               hready_resp_q <= 1'b1;
               hresp_q       <= HRESP_ERROR;
            end
            default: begin
               state_q       <= ACTIVE;
               hready_resp_q <= 1'b1;
               hresp_q       <= HRESP_OKAY;
            end
         endcase
      end
   end

   // The single SRAM port serves, in priority: the write data phase, the stalled read, a fresh read.
   always_comb begin
      sram_cs_n  = '1;
      sram_we_n  = 1'b1;
      sram_be_n  = '1;
      sram_addr  = '0;
      sram_wdata = '0;
      if (!hreset) begin
         if (wr_pend_q) begin
            sram_cs_n[wr_q.bank] = 1'b0;
            sram_we_n            = 1'b0;
            sram_be_n            = ~wr_q.be;
            sram_addr            = wr_q.word;
            sram_wdata           = hwdata;
         end else if (state_q == STALL) begin
            sram_cs_n[st_bank_q] = 1'b0;
            sram_addr            = st_word_q;
         end else if (issue_rd) begin
            sram_cs_n[dec_bank]  = 1'b0;
            sram_addr            = dec_word;
         end
      end
   end

   assign hrdata      = (rd_pend_q && !hreset) ? sram_rdata[int'(rd_bank_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign hready_resp = hready_resp_q;
   assign hresp       = hresp_q;

endmodule

// File: tb/tb_ahb_sramc_mb.sv
// Directed bench for ahb_sramc_mb with a behavioural four-bank SRAM and a single-master AHB driver.
module tb_ahb_sramc_mb;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        hsel, hready, hwrite;
   logic [31:0] haddr, hwdata, hrdata;
   logic [2:0]  hsize;
   logic [1:0]  htrans, hresp;
   logic        hready_resp;
   logic [3:0]  sram_cs_n, sram_be_n;
   logic        sram_we_n;
   logic [11:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [127:0] sram_rdata;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 hclk = ~hclk;
   assign hready = hready_resp;

   ahb_sramc_mb dut (
      .hclk(hclk), .hreset(hreset), .hsel(hsel), .hready(hready), .haddr(haddr),
      .hwrite(hwrite), .hsize(hsize), .htrans(htrans), .hwdata(hwdata), .hrdata(hrdata),
      .hready_resp(hready_resp), .hresp(hresp), .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n),
      .sram_be_n(sram_be_n), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   logic [31:0] mem [4][4096];
   logic [31:0] rq [4];

   always @(posedge hclk) begin
      for (int b = 0; b < 4; b++) begin
         if (!sram_cs_n[b]) begin
            if (!sram_we_n) begin
               for (int l = 0; l < 4; l++) begin
                  if (!sram_be_n[l]) mem[b][sram_addr][l*8 +: 8] <= sram_wdata[l*8 +: 8];
               end
            end else begin
               rq[b] <= mem[b][sram_addr];
            end
         end
      end
   end
   assign sram_rdata = {rq[3], rq[2], rq[1], rq[0]};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic bus(input logic rst, input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd);
      @(negedge hclk);
      hreset = rst; hsel = sel; htrans = trans; hwrite = wr;
      haddr = addr; hsize = size; hwdata = wd;
      #2;
   endtask

   task automatic idle(input logic [31:0] wd);
      bus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 3'b010, wd);
   endtask
   task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd);
      bus(1'b0, 1'b1, 2'b10, 1'b1, addr, size, wd);
   endtask
   task automatic rd(input logic [31:0] addr, input logic [31:0] wd);
      bus(1'b0, 1'b1, 2'b10, 1'b0, addr, 3'b010, wd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] e;
      hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      haddr = '0; hsize = 3'b010; hwdata = '0;
      repeat (3) bus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 3'b010, 32'h0);

      idle(32'h0);
      chk("rst_hrdata", hrdata, 32'h0);
      chk("rst_ready", 32'(hready_resp), 32'h1);
      chk("rst_hresp", 32'(hresp), 32'h0);
      chk("rst_cs_n", 32'(sram_cs_n), 32'hF);
      chk("rst_we_n", 32'(sram_we_n), 32'h1);
      chk("rst_be_n", 32'(sram_be_n), 32'hF);
      chk("rst_addr", 32'(sram_addr), 32'h0);
      chk("rst_wdata", sram_wdata, 32'h0);

      // write then read back 0x1004 (bank 0, word 0x401)
      wr(32'h0000_1004, 3'b010, 32'h0);
      chk("wr_addr_ready", 32'(hready_resp), 32'h1);
      chk("wr_addr_no_cs", 32'(sram_cs_n), 32'hF);
      idle(32'hDEAD_BEEF);
      chk("wr_cs_n", 32'(sram_cs_n), 32'hE);
      chk("wr_we_n", 32'(sram_we_n), 32'h0);
      chk("wr_be_n", 32'(sram_be_n), 32'h0);
      chk("wr_addr", 32'(sram_addr), 32'h401);
      chk("wr_wdata", sram_wdata, 32'hDEAD_BEEF);
      rd(32'h0000_1004, 32'h0);
      chk("rd_cs_n", 32'(sram_cs_n), 32'hE);
      chk("rd_we_n", 32'(sram_we_n), 32'h1);
      chk("rd_addr", 32'(sram_addr), 32'h401);
      idle(32'h0);
      chk("rd_data", hrdata, 32'hDEAD_BEEF);
      chk("rd_ready", 32'(hready_resp), 32'h1);

      // byte and halfword lanes
      wr(32'h8, 3'b010, 32'h0);
      wr(32'h9, 3'b000, 32'h1122_3344);
      chk("be_word", 32'(sram_be_n), 32'h0);
      chk("be_word_addr", 32'(sram_addr), 32'h2);
      wr(32'hA, 3'b001, 32'h0000_AA00);
      chk("be_byte1", 32'(sram_be_n), 32'hD);
      idle(32'h5566_0000);
      chk("be_half2", 32'(sram_be_n), 32'h3);
      idle(32'h0);
      rd(32'h8, 32'h0);
      idle(32'h0);
      chk("byte_merge", hrdata, 32'h5566_AA44);

      // write immediately followed by read of the same word
      wr(32'h20, 3'b010, 32'h0);
      rd(32'h20, 32'h1234);
      chk("cf_wr_ready", 32'(hready_resp), 32'h1);
      chk("cf_wr_cs", 32'(sram_cs_n), 32'hE);
      chk("cf_wr_we", 32'(sram_we_n), 32'h0);
      idle(32'h0);
      chk("cf_stall_ready", 32'(hready_resp), 32'h0);
      chk("cf_stall_cs", 32'(sram_cs_n), 32'hE);
      chk("cf_stall_we", 32'(sram_we_n), 32'h1);
      chk("cf_stall_addr", 32'(sram_addr), 32'h8);
      idle(32'h0);
      chk("cf_ready", 32'(hready_resp), 32'h1);
      chk("cf_data", hrdata, 32'h1234);
      idle(32'h0);
      chk("cf_one_wait", 32'(hready_resp), 32'h1);
      chk("cf_hrdata_idle", hrdata, 32'h0);

      // bank sweep: word 0 of bank n holds n
      for (int n = 0; n < 4; n++) begin
         wr(32'(n) << 14, 3'b010, (n == 0) ? 32'h0 : 32'(n - 1));
         if (n > 0) begin
            e = ~(4'b0001 << (n - 1));
            chk("sweep_wr_cs", 32'(sram_cs_n), 32'(e));
         end
      end
      idle(32'h3);
      chk("sweep_wr_cs3", 32'(sram_cs_n), 32'h7);
      for (int n = 0; n < 4; n++) begin
         rd(32'(n) << 14, 32'h0);
         e = ~(4'b0001 << n);
         chk("sweep_rd_cs", 32'(sram_cs_n), 32'(e));
         if (n > 0) chk("sweep_rd_data", hrdata, 32'(n - 1));
      end
      idle(32'h0);
      chk("sweep_rd_data3", hrdata, 32'h3);

      // illegal size at a 32-bit bus, then a normal read accepted in ERR2
      bus(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 3'b011, 32'h0);
      chk("sz_no_cs", 32'(sram_cs_n), 32'hF);
      idle(32'h0);
      chk("sz_err1_hresp", 32'(hresp), 32'h1);
      chk("sz_err1_ready", 32'(hready_resp), 32'h0);
      chk("sz_err1_cs", 32'(sram_cs_n), 32'hF);
      rd(32'h0000_1004, 32'h0);
      chk("sz_err2_hresp", 32'(hresp), 32'h1);
      chk("sz_err2_ready", 32'(hready_resp), 32'h1);
      chk("sz_err2_accept", 32'(sram_cs_n), 32'hE);
      idle(32'h0);
      chk("sz_after_hresp", 32'(hresp), 32'h0);
      chk("sz_after_data", hrdata, 32'hDEAD_BEEF);

      rd(32'h0001_0000, 32'h0);
`ifdef SRAMC_ADDR_CHECK_EN
      chk("oor_no_cs", 32'(sram_cs_n), 32'hF);
      idle(32'h0);
      chk("oor_err1_hresp", 32'(hresp), 32'h1);
      chk("oor_err1_ready", 32'(hready_resp), 32'h0);
      chk("oor_err1_cs", 32'(sram_cs_n), 32'hF);
      idle(32'h0);
      chk("oor_err2_hresp", 32'(hresp), 32'h1);
      chk("oor_err2_ready", 32'(hready_resp), 32'h1);
      idle(32'h0);
      chk("oor_done_hresp", 32'(hresp), 32'h0);
`else
      chk("alias_cs", 32'(sram_cs_n), 32'hE);
      chk("alias_addr", 32'(sram_addr), 32'h0);
      idle(32'h0);
      chk("alias_hresp", 32'(hresp), 32'h0);
      chk("alias_ready", 32'(hready_resp), 32'h1);
      chk("alias_data", hrdata, 32'h0);
`endif

      // reset during STALL, and reset dropping a pending write
      wr(32'h28, 3'b010, 32'h0);
      idle(32'h1111);
      wr(32'h24, 3'b010, 32'h0);
      rd(32'h24, 32'h5555);
      bus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 3'b010, 32'h0);
      chk("rst_stall_cs", 32'(sram_cs_n), 32'hF);
      idle(32'h0);
      chk("rst_stall_ready", 32'(hready_resp), 32'h1);
      chk("rst_stall_hresp", 32'(hresp), 32'h0);
      chk("rst_stall_cs_after", 32'(sram_cs_n), 32'hF);
      chk("rst_stall_hrdata", hrdata, 32'h0);
      wr(32'h28, 3'b010, 32'h0);
      bus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 3'b010, 32'h7777);
      chk("rst_wr_cs", 32'(sram_cs_n), 32'hF);
      chk("rst_wr_we", 32'(sram_we_n), 32'h1);
      idle(32'h0);
      rd(32'h28, 32'h0);
      rd(32'h24, 32'h0);
      chk("rst_wr_dropped", hrdata, 32'h1111);
      idle(32'h0);
      chk("stall_write_kept", hrdata, 32'h5555);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
